wam_game_core: RTL and testbench
================================

WAM_GAME_CORE -- requirements
Module: wam_game_core

Interface
REQ-001 SHALL have parameter N_HOLES, default 4, number of mole holes/switches, legal 2..8.
REQ-002 SHALL have parameter SCORE_W, default 8, score width in bits.
REQ-003 SHALL have parameter TICK_DIV, default 50000, clk cycles per game tick, legal >=2.
REQ-004 SHALL have parameter MOLE_TICKS, default 8, ticks a mole stays up.
REQ-005 SHALL have parameter GAP_TICKS, default 2, ticks between moles.
REQ-006 SHALL have parameter ROUND_TICKS, default 600, round length in ticks; TL_W = clog2(ROUND_TICKS+1).
REQ-007 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-008 SHALL have ports: clr_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports: start  in  1  synchronous level, begins a round.
REQ-010 SHALL have ports: sw  in  N_HOLES  raw asynchronous whack switches.
REQ-011 SHALL have ports: mole  out  N_HOLES  one-hot raised mole, all-zero when none.
REQ-012 SHALL have ports: score  out  SCORE_W  current score.
REQ-013 SHALL have ports: time_left  out  TL_W  ticks remaining in round.
REQ-014 SHALL have ports: playing  out  1  high during a round; game_over  out  1  high after a round ends.

Function
REQ-015 SHALL synchronise sw through two flops; whack on hole i = rising edge of synchronised bit i (3rd flop compare); latency sw->whack 3 cycles.
REQ-016 SHALL run a prescaler 0..TICK_DIV-1 only while playing; tick = 1-cycle pulse at TICK_DIV-1, then wrap to 0; prescaler cleared on round start.
REQ-017 SHALL free-run a 16-bit Galois LFSR (taps 16,14,13,11) every cycle, seed 16'hACE1 at reset, never all-zero.
REQ-018 SHALL implement FSM IDLE, SPAWN, UP, GAP, OVER.
REQ-019 IDLE: start=1 -> SPAWN; score:=0, time_left:=ROUND_TICKS.
REQ-020 SPAWN: idx = LFSR[2:0] mod 8; idx<N_HOLES -> mole:=one-hot(idx), UP, tick counter:=0; else stay SPAWN one cycle and retry.
REQ-021 UP: whack on mole hole -> score+1 saturating at all-ones, mole:=0, GAP; MOLE_TICKS ticks elapsed without hit -> mole:=0, GAP.
REQ-022 GAP: after GAP_TICKS ticks -> SPAWN.
REQ-023 SHALL decrement time_left on each tick in SPAWN/UP/GAP; on transition to 0 -> OVER same edge, mole:=0.
REQ-024 Hit and time_left reaching 0 on same cycle: hit scored, then OVER.
REQ-025 Several whack edges in one cycle: hit if any edge on mole hole; at most one score change per cycle.
REQ-026 OVER: score and time_left (0) held; start=1 -> behaves as IDLE start (restart, score cleared).
REQ-027 start while in SPAWN/UP/GAP SHALL be ignored.
REQ-028 playing=1 in SPAWN/UP/GAP; game_over=1 only in OVER; both registered.

Reset
REQ-029 clr_n=0 SHALL asynchronously force IDLE, mole=0, score=0, time_left=0, playing=0, game_over=0, prescaler=0, sync flops=0, LFSR=16'hACE1.
REQ-030 Reset mid-round SHALL abandon the round without restoring score; release restarts in IDLE.

Configuration
REQ-031 Macro WAM_PENALTY_EN defined: in UP, whack on a non-mole hole with no hit edge that cycle SHALL decrement score, saturating at 0, mole stays up.
REQ-032 WAM_PENALTY_EN undefined: wrong-hole whacks and all whacks outside UP SHALL have no effect.

Verification (TICK_DIV=4, MOLE_TICKS=3, GAP_TICKS=2, ROUND_TICKS=20, N_HOLES=4)
REQ-033 Reset then start pulse -> playing=1 next cycle, time_left=20, score=0, one-hot mole within 2 cycles.
REQ-034 Rise sw bit matching mole -> 3 cycles later score=1, mole=0, next mole after 2 ticks (8 cycles).
REQ-035 No whack -> mole drops after 3 ticks, score unchanged; after 20 ticks (80 cycles) game_over=1, time_left=0, mole=0.
REQ-036 Penalty build, score=1, wrong-hole whack -> score=0; second wrong whack -> score stays 0; non-penalty build -> score stays 1.
REQ-037 SCORE_W=2 with 4 hits -> score saturates at 3; hit coincident with final tick -> score incremented and OVER.
REQ-038 clr_n low mid-UP -> all outputs zero immediately without clk; start in OVER -> score=0, time_left=20.

Source files
------------

// File: rtl/wam_game_core.sv
// wam_game_core: whack-a-mole round controller (random mole, tick timing, score, round timer).
// Define WAM_PENALTY_EN to make wrong-hole whacks during a raised mole cost one point.
module wam_game_core #(
  parameter int N_HOLES = 4,
  parameter int SCORE_W = 8,
  parameter int TICK_DIV = 50000,
  parameter int MOLE_TICKS = 8,
  parameter int GAP_TICKS = 2,
  parameter int ROUND_TICKS = 600,
  localparam int TL_W = $clog2(ROUND_TICKS + 1)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [TL_W-1:0]    time_left,
  output logic               playing,
  output logic               game_over
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2((MOLE_TICKS > GAP_TICKS ? MOLE_TICKS : GAP_TICKS) + 1);

  typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;

  state_t             state_q, state_d;
  logic [N_HOLES-1:0] s1_q, s2_q, s3_q, mole_q, mole_d, whack;
  logic [PW-1:0]      pre_q, pre_d;
  logic [CW-1:0]      tcnt_q, tcnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TL_W-1:0]    tl_q, tl_d;
  logic               playing_q, over_q;
  logic               act, tick, hit, pen, valid, time_up, launch, mole_end, gap_end;
  logic [2:0]         idx;

  assign whack    = s2_q & ~s3_q;
  assign act      = state_q == SPAWN || state_q == UP || state_q == GAP;
  assign tick     = act && pre_q == PW'(TICK_DIV - 1);
  assign hit      = state_q == UP && |(whack & mole_q);
  assign idx      = lfsr_q[2:0];
  assign valid    = int'(idx) < N_HOLES;
  assign time_up  = tick && tl_q == TL_W'(1);
  assign launch   = start && (state_q == IDLE || state_q == OVER);
  assign mole_end = state_q == UP && tick && tcnt_q == CW'(MOLE_TICKS - 1);
  assign gap_end  = state_q == GAP && tick && tcnt_q == CW'(GAP_TICKS - 1);
`ifdef WAM_PENALTY_EN
  assign pen = state_q == UP && !hit && |(whack & ~mole_q);
`else
  assign pen = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pre_q     <= '0;
      tcnt_q    <= '0;
      lfsr_q    <= 16'hACE1;
      mole_q    <= '0;
      score_q   <= '0;
      tl_q      <= '0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= sw;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pre_q     <= pre_d;
      tcnt_q    <= tcnt_d;
      lfsr_q    <= lfsr_d;
      mole_q    <= mole_d;
      score_q   <= score_d;
      tl_q      <= tl_d;
      playing_q <= state_d == SPAWN || state_d == UP || state_d == GAP;
      over_q    <= state_d == OVER;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: state_d = start ? SPAWN : state_q;
      SPAWN:      state_d = valid ? UP : SPAWN;
      UP:         state_d = (hit || mole_end) ? GAP : UP;
      GAP:        state_d = gap_end ? SPAWN : GAP;
      default:    state_d = IDLE;
    endcase
    // The round timer outranks everything; a same-cycle hit is still scored below.
    if (time_up) state_d = OVER;
  end

  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    pre_d   = launch ? '0 : act ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
    tcnt_d  = state_d != state_q ? '0 : tick ? tcnt_q + CW'(1) : tcnt_q;
    mole_d  = state_d != UP ? '0 : state_q == SPAWN ? N_HOLES'(1) << idx : mole_q;
    score_d = launch ? '0 :
              hit ? (&score_q ? score_q : score_q + SCORE_W'(1)) :
              pen ? (score_q == '0 ? score_q : score_q - SCORE_W'(1)) : score_q;
    tl_d    = launch ? TL_W'(ROUND_TICKS) : tick ? tl_q - TL_W'(1) : tl_q;
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign time_left = tl_q;
  assign playing   = playing_q;
  assign game_over = over_q;
endmodule

// File: tb/tb_wam_game_core.sv
// tb_wam_game_core: directed checks of round flow, hits, timeouts, saturation, penalty option and reset.
module tb_wam_game_core;
  logic       clk = 1'b0;
  logic       clr_n, start, start_s;
  logic [3:0] sw, sw_s, mole, ms, m, wrong;
  logic [7:0] score;
  logic [1:0] score_s;
  logic [4:0] tl, tl_s;
  logic       playing, go, playing_s, go_s, ok;
  int         n_tests = 0, n_fail = 0, cyc = 0, t0 = 0;

`ifdef WAM_PENALTY_EN
  localparam int EXP1 = 0, EXP2 = 0;
`else
  localparam int EXP1 = 1, EXP2 = 1;
`endif

  wam_game_core #(.N_HOLES(4), .SCORE_W(8), .TICK_DIV(4), .MOLE_TICKS(3), .GAP_TICKS(2), .ROUND_TICKS(20)) u_dut (
    .clk(clk), .clr_n(clr_n), .start(start), .sw(sw), .mole(mole), .score(score),
    .time_left(tl), .playing(playing), .game_over(go));

  wam_game_core #(.N_HOLES(4), .SCORE_W(2), .TICK_DIV(4), .MOLE_TICKS(100), .GAP_TICKS(2), .ROUND_TICKS(30)) u_sat (
    .clk(clk), .clr_n(clr_n), .start(start_s), .sw(sw_s), .mole(ms), .score(score_s),
    .time_left(tl_s), .playing(playing_s), .game_over(go_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_mole(input bit sel, input int lim, output logic found);
    found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      step(1);
      found = sel ? ms != 0 : mole != 0;
    end
  endtask

  task automatic wait_over(input bit sel, input int lim, output logic found);
    found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      step(1);
      found = sel ? go_s : go;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b0; start = 1'b0; sw = '0; start_s = 1'b0; sw_s = '0;
    #3;
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_tl", tl, 0);
    check("rst_playing", playing, 0);
    check("rst_over", go, 0);
    step(1);
    clr_n = 1'b1;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    t0 = cyc;
    check("start_playing", playing, 1);
    check("start_tl", tl, 20);
    check("start_score", score, 0);
    check("start_over", go, 0);
    wait_mole(0, 8, ok);
    check("mole1_up", ok, 1);
    check("mole1_onehot", $onehot(mole), 1);
    m = mole;
    sw = m;
    step(2);
    check("hit_latency", score, 0);
    step(1);
    check("hit_score", score, 1);
    check("hit_mole_down", mole, 0);
    sw = '0;
    step(4);
    check("gap_no_mole", mole, 0);
    wait_mole(0, 16, ok);
    check("mole2_up", ok, 1);
    m = mole;
    wrong = {m[2:0], m[3]};
    sw = wrong;
    step(3);
    check("wrong1_score", score, EXP1);
    sw = '0;
    step(1);
    sw = wrong;
    step(3);
    check("wrong2_score", score, EXP2);
    check("wrong_mole_kept", mole, m);
    sw = '0;
    step(1);
    check("mole_still_up", mole, m);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      step(1);
      ok = mole == 0;
    end
    check("mole_timeout", ok, 1);
    check("timeout_score", score, EXP2);
    wait_over(0, 100, ok);
    check("over_seen", ok, 1);
    check("over_cycles", cyc - t0, 80);
    check("over_tl", tl, 0);
    check("over_mole", mole, 0);
    check("over_playing", playing, 0);
    check("over_score", score, EXP2);
    step(3);
    check("over_hold_score", score, EXP2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("restart_score", score, 0);
    check("restart_tl", tl, 20);
    check("restart_playing", playing, 1);
    check("restart_over", go, 0);

    start_s = 1'b1;
    step(1);
    start_s = 1'b0;
    check("sat_tl", tl_s, 30);
    for (int h = 0; h < 4; h++) begin
      wait_mole(1, 40, ok);
      check("sat_mole_up", ok, 1);
      sw_s = ms;
      step(3);
      check("sat_score", score_s, h < 3 ? h + 1 : 3);
      sw_s = '0;
    end
    wait_over(1, 150, ok);
    check("sat_over", ok, 1);
    check("sat_over_score", score_s, 3);
    start_s = 1'b1;
    step(1);
    start_s = 1'b0;
    t0 = cyc;
    check("sat_restart_score", score_s, 0);
    wait_mole(1, 10, ok);
    check("fin_mole_up", ok, 1);
    while (cyc - t0 < 117) step(1);
    sw_s = ms;
    step(2);
    check("fin_pre_score", score_s, 0);
    check("fin_pre_over", go_s, 0);
    check("fin_pre_mole", ms != 0, 1);
    step(1);
    check("fin_score", score_s, 1);
    check("fin_over", go_s, 1);
    check("fin_mole", ms, 0);
    check("fin_tl", tl_s, 0);
    sw_s = '0;

    wait_over(0, 100, ok);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_mole(0, 8, ok);
    check("rst_round_mole", ok, 1);
    sw = mole;
    step(3);
    sw = '0;
    check("rst_round_score", score, 1);
    wait_mole(0, 16, ok);
    check("rst_round_mole2", ok, 1);
    #2 clr_n = 1'b0;
    #1;
    check("async_mole", mole, 0);
    check("async_score", score, 0);
    check("async_tl", tl, 0);
    check("async_playing", playing, 0);
    check("async_over", go, 0);
    step(1);
    clr_n = 1'b1;
    step(2);
    check("post_rst_idle", playing, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
